// File: rtl/exec_addx_seq_if.sv
// Handshake and addx-unit bundle for the multi-precision add/sub sequencer.
// The slave modport is the sequencer's view; master is the environment's view.
interface exec_addx_seq_if #(
  parameter int W_OPR   = 32,
  parameter int W_FLAGS = 4,
  parameter int W_CNT   = 4
);
  logic               cmd_valid_i;
  logic               cmd_ready_o;
  logic               cmd_sub_i;
  logic [W_CNT-1:0]   cmd_words_i;

  logic               in_valid_i;
  logic               in_ready_o;
  logic [W_OPR-1:0]   in_a_i;
  logic [W_OPR-1:0]   in_b_i;

  logic               res_valid_o;
  logic               res_ready_i;
  logic [W_OPR-1:0]   res_data_o;
  logic               res_last_o;
  logic [W_FLAGS-1:0] res_flags_o;

  logic [W_OPR-1:0]   addx_opr0_o;
  logic [W_OPR-1:0]   addx_opr1_o;
  logic [1:0]         addx_select_o;
  logic [W_FLAGS-1:0] addx_flags_o;
  logic [W_OPR-1:0]   addx_result_i;
  logic [W_FLAGS-1:0] addx_flags_i;

  modport slave (
    input  cmd_valid_i, cmd_sub_i, cmd_words_i,
    input  in_valid_i, in_a_i, in_b_i,
    input  res_ready_i,
    input  addx_result_i, addx_flags_i,
    output cmd_ready_o, in_ready_o,
    output res_valid_o, res_data_o, res_last_o, res_flags_o,
    output addx_opr0_o, addx_opr1_o, addx_select_o, addx_flags_o
  );

  modport master (
    output cmd_valid_i, cmd_sub_i, cmd_words_i,
    output in_valid_i, in_a_i, in_b_i,
    output res_ready_i,
    output addx_result_i, addx_flags_i,
    input  cmd_ready_o, in_ready_o,
    input  res_valid_o, res_data_o, res_last_o, res_flags_o,
    input  addx_opr0_o, addx_opr1_o, addx_select_o, addx_flags_o
  );
endinterface

// File: rtl/exec_addx_seq.sv
// Multi-precision add/subtract sequencer: drives a single-word addx unit one word
// per cycle, least-significant first, chaining carry/borrow between words.
module exec_addx_seq #(
  parameter int W_OPR   = 32,
  parameter int W_FLAGS = 4,
  parameter int W_CNT   = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  exec_addx_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t             state_q, state_d;

  logic               sub_q;
  logic [W_CNT-1:0]   words_q;
  logic [W_CNT-1:0]   cnt_q;
  logic               chain_q;
  logic               zacc_q;

  logic               res_valid_q;
  logic               res_last_q;
  logic [W_OPR-1:0]   res_data_q;
  logic [W_FLAGS-1:0] res_flags_q;

  logic               cmd_fire;
  logic               in_ready;
  logic               in_fire;
  logic               res_fire;
  logic               last_word;

  assign cmd_fire  = (state_q == ST_IDLE) && bus.cmd_valid_i;
  // The output slot frees up in the same cycle it is consumed, so words can stream at 1/cycle.
  assign in_ready  = (state_q == ST_RUN) && (!res_valid_q || bus.res_ready_i);
  assign in_fire   = in_ready && bus.in_valid_i;
  assign res_fire  = res_valid_q && bus.res_ready_i;
  assign last_word = (cnt_q == (words_q - W_CNT'(1)));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignment so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (cmd_fire)              state_d = ST_RUN;
      ST_RUN:   if (in_fire && last_word)  state_d = ST_FLUSH;
      ST_FLUSH: if (res_fire)              state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operation context: mode, length, word counter, carry chain, zero accumulator
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sub_q   <= 1'b0;
      words_q <= '0;
      cnt_q   <= '0;
      chain_q <= 1'b0;
      zacc_q  <= 1'b1;
    end else if (cmd_fire) begin
      sub_q   <= bus.cmd_sub_i;
      words_q <= (bus.cmd_words_i == '0) ? W_CNT'(1) : bus.cmd_words_i;
      cnt_q   <= '0;
      chain_q <= 1'b0;
      zacc_q  <= 1'b1;
    end else if (in_fire) begin
      // Subtract keeps the borrow (inverted raw carry) so the SBC carry-in works out.
      chain_q <= sub_q ? ~bus.addx_flags_i[0] : bus.addx_flags_i[0];
      zacc_q  <= zacc_q & bus.addx_flags_i[1];
      cnt_q   <= cnt_q + W_CNT'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // One-deep result register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_data_q  <= '0;
      res_flags_q <= '0;
    end else if (in_fire) begin
      res_valid_q <= 1'b1;
      res_last_q  <= last_word;
      res_data_q  <= bus.addx_result_i;
      res_flags_q <= last_word ? {bus.addx_flags_i[3], bus.addx_flags_i[2],
                                  zacc_q & bus.addx_flags_i[1], bus.addx_flags_i[0]}
                               : '0;
    end else if (res_fire) begin
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_flags_q <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.cmd_ready_o   = (state_q == ST_IDLE);
  assign bus.in_ready_o    = in_ready;

  assign bus.res_valid_o   = res_valid_q;
  assign bus.res_data_o    = res_data_q;
  assign bus.res_last_o    = res_last_q;
  assign bus.res_flags_o   = res_flags_q;

  assign bus.addx_opr0_o   = bus.in_a_i;
  assign bus.addx_opr1_o   = bus.in_b_i;
  assign bus.addx_select_o = {(cnt_q != '0), sub_q};
  assign bus.addx_flags_o  = {{(W_FLAGS-1){1'b0}}, chain_q};

endmodule

// File: tb/tb_exec_addx_seq.sv
// Bench for exec_addx_seq: wide-integer reference model, a behavioural addx unit,
// directed corner cases plus randomized multi-word commands.
module tb_exec_addx_seq;

  localparam int W      = 16;
  localparam int WF     = 4;
  localparam int WC     = 4;
  localparam int BUDGET = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exec_addx_seq_if #(.W_OPR(W), .W_FLAGS(WF), .W_CNT(WC)) bus ();

  exec_addx_seq #(.W_OPR(W), .W_FLAGS(WF), .W_CNT(WC)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Single-word add/sub-with-carry unit: ADD, SUB, ADC, SBC (SBC carry-in = 1 ^ flags[0]).
  always_comb begin : addx_unit
    logic [W-1:0] opb;
    logic         cin;
    logic [W:0]   s;
    opb = bus.addx_select_o[0] ? ~bus.addx_opr1_o : bus.addx_opr1_o;
    if (bus.addx_select_o[1]) cin = bus.addx_select_o[0] ? ~bus.addx_flags_o[0] : bus.addx_flags_o[0];
    else                      cin = bus.addx_select_o[0];
    s = {1'b0, bus.addx_opr0_o} + {1'b0, opb} + {{W{1'b0}}, cin};
    bus.addx_result_i = s[W-1:0];
    bus.addx_flags_i  = {(bus.addx_opr0_o[W-1] == opb[W-1]) && (s[W-1] != bus.addx_opr0_o[W-1]),
                         s[W-1], (s[W-1:0] == '0), s[W]};
  end

  typedef struct packed {
    logic [W-1:0]  data;
    logic          last;
    logic [WF-1:0] flags;
  } res_t;

  typedef struct packed {
    logic [1:0]   sel;
    logic         chain;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } op_t;

  res_t exp_res[$];
  res_t seen_res[$];
  op_t  exp_op[$];
  op_t  seen_op[$];

  int          n_checks = 0;
  int          n_err    = 0;
  int unsigned cyc      = 0;
  int          stall_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // Reference: treat the N-word operands as plain integers and derive every word and flag.
  task automatic expect_cmd(input bit sub, input int n, input logic [255:0] a_in, input logic [255:0] b_in);
    logic [255:0] mask, a, b, r, mi, lo_sum;
    logic         c, z, nf, v, sa, sb;
    res_t         re;
    op_t          oe;
    mask = (256'd1 << (n * W)) - 256'd1;
    a    = a_in & mask;
    b    = b_in & mask;
    r    = sub ? (a - b) : (a + b);
    c    = sub ? (a >= b) : r[n * W];
    r    = r & mask;
    z    = (r == '0);
    nf   = r[n * W - 1];
    sa   = a[n * W - 1];
    sb   = b[n * W - 1];
    v    = sub ? ((sa != sb) && (nf != sa)) : ((sa == sb) && (nf != sa));
    for (int i = 0; i < n; i++) begin
      mi       = (256'd1 << (i * W)) - 256'd1;
      lo_sum   = (a & mi) + (b & mi);
      oe.sel   = {(i != 0), sub};
      oe.chain = sub ? ((a & mi) < (b & mi)) : lo_sum[i * W];
      oe.a     = a[i * W +: W];
      oe.b     = b[i * W +: W];
      exp_op.push_back(oe);
      re.data  = r[i * W +: W];
      re.last  = (i == n - 1);
      re.flags = re.last ? {v, nf, z, c} : 4'b0000;
      exp_res.push_back(re);
    end
  endtask

  // Compare process: every handshake and every held cycle is checked on the falling edge.
  op_t          obs_op, e_op;
  res_t         obs_res, e_res;
  logic         hold_prev = 1'b0;
  logic [W-1:0] hold_data;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (bus.in_valid_i && bus.in_ready_o) begin
        obs_op = {bus.addx_select_o, bus.addx_flags_o[0], bus.addx_opr0_o, bus.addx_opr1_o};
        seen_op.push_back(obs_op);
        if (exp_op.size() == 0) fail("unexpected_operand_handshake");
        else begin
          e_op = exp_op.pop_front();
          check("addx_select", 64'(obs_op.sel), 64'(e_op.sel));
          check("addx_chain",  64'(obs_op.chain), 64'(e_op.chain));
          check("addx_opr0",   64'(obs_op.a), 64'(e_op.a));
          check("addx_opr1",   64'(obs_op.b), 64'(e_op.b));
        end
      end
      if (hold_prev) begin
        check("held_valid", 64'(bus.res_valid_o), 64'(1));
        check("held_data",  64'(bus.res_data_o), 64'(hold_data));
      end
      if (bus.res_valid_o && bus.res_ready_i) begin
        obs_res = {bus.res_data_o, bus.res_last_o, bus.res_flags_o};
        seen_res.push_back(obs_res);
        if (exp_res.size() == 0) fail("unexpected_result_word");
        else begin
          e_res = exp_res.pop_front();
          check("res_data",  64'(obs_res.data), 64'(e_res.data));
          check("res_last",  64'(obs_res.last), 64'(e_res.last));
          check("res_flags", 64'(obs_res.flags), 64'(e_res.flags));
        end
      end
      if (bus.res_valid_o && !bus.res_ready_i) begin
        stall_cycles++;
        check("in_ready_while_held", 64'(bus.in_ready_o), 64'(0));
      end
      if (!bus.res_last_o) check("flags_zero_unless_last", 64'(bus.res_flags_o), 64'(0));
      hold_prev = bus.res_valid_o && !bus.res_ready_i;
      hold_data = bus.res_data_o;
    end
  end

  // Result-side backpressure: 0 = always ready, 1 = random, 2 = manual_ready.
  int   rr_mode      = 0;
  logic manual_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       bus.res_ready_i = 1'b1;
      1:       bus.res_ready_i = ($urandom_range(0, 3) != 0);
      default: bus.res_ready_i = manual_ready;
    endcase
  end

  task automatic run_cmd(input bit sub, input logic [WC-1:0] field, input logic [255:0] a,
                         input logic [255:0] b, input int feed_limit, input bit gaps, input bit check_rate);
    int n, budget, first_hs, last_hs;
    bit hs;
    n        = (field == '0) ? 1 : int'(field);
    first_hs = 0;
    last_hs  = 0;
    expect_cmd(sub, n, a, b);
    bus.cmd_sub_i   = sub;
    bus.cmd_words_i = field;
    bus.cmd_valid_i = 1'b1;
    budget = 0;
    do begin
      @(negedge clk); hs = bus.cmd_ready_o;
      @(posedge clk); #1; budget++;
    end while (!hs && budget < BUDGET);
    bus.cmd_valid_i = 1'b0;
    bus.cmd_sub_i   = 1'($urandom);
    bus.cmd_words_i = WC'($urandom);
    bus.in_valid_i  = 1'b0;
    if (!hs) begin fail("cmd_handshake_timeout"); return; end
    for (int i = 0; i < n && i < feed_limit; i++) begin
      if (gaps) begin
        bus.in_valid_i = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      bus.in_a_i     = a[i * W +: W];
      bus.in_b_i     = b[i * W +: W];
      bus.in_valid_i = 1'b1;
      budget = 0;
      do begin
        @(negedge clk); hs = bus.in_ready_o;
        @(posedge clk); #1; budget++;
      end while (!hs && budget < BUDGET);
      if (!hs) begin bus.in_valid_i = 1'b0; fail("operand_handshake_timeout"); return; end
      if (i == 0) first_hs = int'(cyc);
      last_hs = int'(cyc);
    end
    bus.in_valid_i = 1'b0;
    if (check_rate && feed_limit >= n) check("full_rate_span", 64'(last_hs - first_hs), 64'(n - 1));
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_res.size() != 0 && budget < BUDGET) begin @(posedge clk); #1; budget++; end
    if (exp_res.size() != 0) fail("result_drain_timeout");
  endtask

  task automatic check_seen(input string tag, input int idx, input logic [W-1:0] d,
                            input logic l, input logic [WF-1:0] f);
    if (idx >= seen_res.size()) fail(tag);
    else begin
      check({tag, "_data"},  64'(seen_res[idx].data), 64'(d));
      check({tag, "_last"},  64'(seen_res[idx].last), 64'(l));
      check({tag, "_flags"}, 64'(seen_res[idx].flags), 64'(f));
    end
  endtask

  task automatic check_op(input string tag, input int idx, input logic [1:0] sel, input logic chain);
    if (idx >= seen_op.size()) fail(tag);
    else begin
      check({tag, "_select"}, 64'(seen_op[idx].sel), 64'(sel));
      check({tag, "_chain"},  64'(seen_op[idx].chain), 64'(chain));
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  logic [255:0] ra, rb;

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_sub_i   = 1'b0;
    bus.cmd_words_i = '0;
    bus.in_valid_i  = 1'b0;
    bus.in_a_i      = '0;
    bus.in_b_i      = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_res_valid",   64'(bus.res_valid_o), 64'(0));
    check("rst_res_data",    64'(bus.res_data_o), 64'(0));
    check("rst_res_last",    64'(bus.res_last_o), 64'(0));
    check("rst_res_flags",   64'(bus.res_flags_o), 64'(0));
    check("rst_cmd_ready",   64'(bus.cmd_ready_o), 64'(1));
    check("rst_in_ready",    64'(bus.in_ready_o), 64'(0));
    check("rst_addx_select", 64'(bus.addx_select_o), 64'(0));
    check("rst_addx_flags",  64'(bus.addx_flags_o), 64'(0));
    @(posedge clk); #1;

    // 1-word add overflowing into the sign bit
    rr_mode = 0;
    seen_res.delete(); seen_op.delete();
    run_cmd(1'b0, 4'd1, 256'h7FFF, 256'h0001, 99, 1'b0, 1'b0);
    drain();
    check("d1_count", 64'(seen_res.size()), 64'(1));
    check_seen("d1_w0", 0, 16'h8000, 1'b1, 4'b1100);
    check_op("d1_op0", 0, 2'b00, 1'b0);

    // 2-word add with carry across the word boundary
    seen_res.delete(); seen_op.delete();
    run_cmd(1'b0, 4'd2, 256'h0001_FFFF, 256'h0000_0001, 99, 1'b0, 1'b0);
    drain();
    check_seen("d2_w0", 0, 16'h0000, 1'b0, 4'b0000);
    check_seen("d2_w1", 1, 16'h0002, 1'b1, 4'b0000);
    check_op("d2_op1", 1, 2'b10, 1'b1);

    // 2-word subtract with borrow across the word boundary
    seen_res.delete(); seen_op.delete();
    run_cmd(1'b1, 4'd2, 256'h0001_0000, 256'h0000_0001, 99, 1'b0, 1'b0);
    drain();
    check_seen("d3_w0", 0, 16'hFFFF, 1'b0, 4'b0000);
    check_seen("d3_w1", 1, 16'h0000, 1'b1, 4'b0001);
    check_op("d3_op0", 0, 2'b01, 1'b0);
    check_op("d3_op1", 1, 2'b11, 1'b1);

    // Equal operands: zero only because every word is zero
    seen_res.delete(); seen_op.delete();
    run_cmd(1'b1, 4'd2, 256'h1234_5678, 256'h1234_5678, 99, 1'b0, 1'b0);
    drain();
    check_seen("d4_w0", 0, 16'h0000, 1'b0, 4'b0000);
    check_seen("d4_w1", 1, 16'h0000, 1'b1, 4'b0011);

    // 4-word add at full rate
    run_cmd(1'b0, 4'd4, 256'h89AB_CDEF_0123_4567, 256'hFEDC_BA98_7654_3210, 99, 1'b0, 1'b1);
    drain();

    // 4-word add with result backpressure mid-stream
    rr_mode = 2; manual_ready = 1'b1; stall_cycles = 0;
    seen_res.delete();
    fork
      run_cmd(1'b0, 4'd4, 256'hFFFF_0000_FFFF_FFFF, 256'h0000_FFFF_0000_0001, 99, 1'b0, 1'b0);
      begin
        repeat (3) @(negedge clk);
        manual_ready = 1'b0;
        repeat (3) @(negedge clk);
        manual_ready = 1'b1;
      end
    join
    drain();
    check("d5_stall_seen", 64'(stall_cycles >= 2), 64'(1));
    check("d5_count", 64'(seen_res.size()), 64'(4));
    rr_mode = 0;

    // Zero word count runs exactly one word
    seen_res.delete();
    run_cmd(1'b1, 4'd0, 256'h0000_0005, 256'h0000_0009, 99, 1'b0, 1'b0);
    drain();
    check("d6_count", 64'(seen_res.size()), 64'(1));
    check_seen("d6_w0", 0, 16'hFFFC, 1'b1, 4'b0100);

    // Asynchronous reset during word 2 of 4
    run_cmd(1'b0, 4'd4, 256'h1111_2222_3333_4444, 256'h0101_0202_0303_0404, 2, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_res_valid", 64'(bus.res_valid_o), 64'(0));
    check("arst_res_data",  64'(bus.res_data_o), 64'(0));
    check("arst_res_last",  64'(bus.res_last_o), 64'(0));
    check("arst_res_flags", 64'(bus.res_flags_o), 64'(0));
    check("arst_in_ready",  64'(bus.in_ready_o), 64'(0));
    exp_res.delete(); exp_op.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("arst_cmd_ready", 64'(bus.cmd_ready_o), 64'(1));
    @(posedge clk); #1;
    seen_res.delete();
    run_cmd(1'b0, 4'd1, 256'h0003, 256'h0004, 99, 1'b0, 1'b0);
    drain();
    check_seen("d7_w0", 0, 16'h0007, 1'b1, 4'b0000);

    // Randomized commands with input gaps, random backpressure and junk on idle inputs
    rr_mode = 1;
    for (int k = 0; k < 60; k++) begin
      ra = '0;
      rb = '0;
      for (int i = 0; i < 15; i++) begin
        ra[i * W +: W] = rand_word();
        rb[i * W +: W] = ($urandom_range(0, 4) == 0) ? ra[i * W +: W] : rand_word();
      end
      run_cmd(1'($urandom), WC'($urandom_range(0, 15)), ra, rb, 99, 1'($urandom), 1'b0);
      bus.in_valid_i = 1'b1;
      bus.in_a_i     = W'($urandom);
      bus.in_b_i     = W'($urandom);
    end
    bus.in_valid_i = 1'b0;
    drain();
    repeat (4) @(posedge clk);
    check("final_op_queue_empty", 64'(exp_op.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/exec_addx_seq.md
Name: exec_addx_seq

Overview:
Multi-precision add/subtract sequencer for the single-word add/sub-with-carry execution unit. It accepts one command (add or subtract, N words), streams operand word pairs least-significant first, and drives the external addx unit one word per cycle. Word 0 uses plain ADD/SUB and later words use ADC/SBC, with the inter-word carry/borrow held in a register. Result words stream out through a one-deep registered output, and the final flags are presented with the last word.

Parameters:
W_OPR, 32, operand/result word width (matches addx unit)
W_FLAGS, 4, flag width, layout {V,N,Z,C} (matches addx unit)
W_CNT, 4, width of word-count field; max operation length 2^W_CNT-1 words

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_sub_i  in  1  1=subtract (A-B), 0=add
cmd_words_i  in  W_CNT  number of words; 0 treated as 1
in_valid_i  in  1  operand word pair valid
in_ready_o  out  1  operand word pair accepted when valid&ready
in_a_i  in  W_OPR  operand A word
in_b_i  in  W_OPR  operand B word
res_valid_o  out  1  result word valid
res_ready_i  in  1  result word consumed when valid&ready
res_data_o  out  W_OPR  result word
res_last_o  out  1  current result word is the final word
res_flags_o  out  W_FLAGS  final flags {V,N,Z,C}; meaningful only when res_last_o=1, else 0
addx_opr0_o  out  W_OPR  to addx opr0_i (= in_a_i)
addx_opr1_o  out  W_OPR  to addx opr1_i (= in_b_i)
addx_select_o  out  2  to addx select_i: {not_first_word, sub}
addx_flags_o  out  W_FLAGS  to addx flags_i: {3'b0, chain}
addx_result_i  in  W_OPR  from addx result_o
addx_flags_i  in  W_FLAGS  from addx flags_o

Behaviour:
- Reset (asynchronous, any state): state=IDLE; res_valid_o=0, res_data_o=0, res_last_o=0, res_flags_o=0; chain=0, word counter=0, zero accumulator=1, sub latch=0.
- cmd_ready_o=1 only in IDLE.
- States:
  - IDLE: on cmd handshake, latch sub and count (0 becomes 1), clear counter, set zero accumulator=1, chain=0, then go to RUN.
  - RUN: in_ready_o = !res_valid_o | res_ready_i. On an operand handshake:
    - register addx_result_i into res_data_o; set res_valid_o=1.
    - update chain = sub ? ~addx_flags_i[0] : addx_flags_i[0].
    - zero accumulator &= addx_flags_i[1]; increment the counter.
    - If this is the last word: res_last_o=1; res_flags_o = {addx_flags_i[3], addx_flags_i[2], zacc & addx_flags_i[1], addx_flags_i[0]}; go to FLUSH.
  - FLUSH: in_ready_o=0; when the last word's res handshake occurs, clear res_valid_o and res_last_o, zero res_flags_o, and go to IDLE. The next command is accepted no earlier than the following cycle.
- Output register: a result word that is not consumed stays held unchanged. Consume and load in the same cycle is allowed, giving full throughput of 1 word/cycle. A result handshake with no new load clears res_valid_o.
- Addx drive (combinational; the addx path is combinational, so all values settle in one cycle):
  - addx_select_o[0] = latched sub.
  - addx_select_o[1] = (counter != 0).
  - addx_flags_o[0] = chain.
  - These values are driven in every state; they are ignored outside operand handshakes.
- Carry convention:
  - For subtract, chain holds the borrow (= NOT raw carry). This makes the addx SBC carry-in (1 ^ chain) correct.
  - For add, chain holds the raw carry.
- Final C is the raw addx carry of the top word: for add, 1 = carry out; for subtract, 1 = no borrow. Final Z is the AND over all words. V and N come from the top word.
- Inputs outside RUN are ignored. in_valid_i and cmd_valid_i may be held high indefinitely without effect.
- Reset mid-operation abandons the operation. No partial flags are reported.

Test Plan:
- W_OPR=16. 1 word add 0x7FFF+0x0001 -> res 0x8000, last=1, flags 4'b1100; addx_select_o=2'b00.
- 2 words add A=0x0001_FFFF, B=0x0000_0001 -> word0 0x0000, word1 0x0002 with addx_select_o=2'b10; final flags 4'b0000.
- 2 words sub A=0x0001_0000, B=0x0000_0001 -> word0 0xFFFF with select 2'b01; word1 0x0000 with select 2'b11 and addx_flags_o[0]=1; final flags 4'b0001.
- 2 words sub equal operands 0x1234_5678 -> words 0x0000, 0x0000; final flags 4'b0011 (Z set only because both words are zero).
- 4 word add with res_ready_i low for 3 cycles mid-stream -> in_ready_o=0 while a result is held, res_data_o stable, no words lost or duplicated; back-to-back words at full rate when res_ready_i=1; cmd_words_i=0 runs exactly 1 word.
- Assert rst_i asynchronously during word 2 of 4 -> all outputs 0 immediately, cmd_ready_o=1 after release; the next 1-word add 0x0003+0x0004 gives 0x0007 with flags 4'b0000.
